// File: rtl/program_loader_if.sv
// Byte-stream input and code-memory write port of the program loader.
// master is the loader side, slave is the byte source / code memory side.
interface program_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  in_byte, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_byte, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/program_loader.sv
// Assembles a header/payload/checksum byte stream into instruction words,
// writes them to code memory and releases the control unit when the checksum matches.
module program_loader #(
  parameter int Instruction_WIDTH       = 16,
  parameter int Instruction_Memory_Size = 16,
  parameter int Instruction_ADDR_WIDTH  = $clog2(Instruction_Memory_Size),
  parameter int BYTES_PER_INST          = Instruction_WIDTH / 8
) (
  input  logic                clock,
  input  logic                reset_bt,
  input  logic                load_start,
  program_loader_if.master    bus,
  output logic                cu_enable,
  output logic                load_done,
  output logic                load_err,
  output logic [7:0]          words_loaded,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    WRITE   = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } state_t;

  state_t                            state_q, state_d;
  logic [2:0]                        byte_cnt_q, byte_cnt_d;
  logic [7:0]                        n_q, n_d;
  logic [7:0]                        csum_q, csum_d;
  logic [7:0]                        words_q, words_d;
  logic [Instruction_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [Instruction_WIDTH-1:0]      shift_q, shift_d;
  logic [Instruction_WIDTH+7:0]      shift_ext;

  logic accept;
  assign accept    = bus.in_valid && bus.in_ready;
  // Widened concatenation keeps the shift legal when a word is a single byte.
  assign shift_ext = {shift_q, bus.in_byte};

  always_ff @(posedge clock or negedge reset_bt) begin
    if (!reset_bt) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      n_q        <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      n_q        <= n_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    n_d        = n_q;
    csum_d     = csum_q;
    words_d    = words_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_start) begin
          state_d    = HEADER;
          csum_d     = '0;
          words_d    = '0;
          addr_d     = '0;
          byte_cnt_d = '0;
        end
      end
      HEADER: begin
        if (accept) begin
          if (bus.in_byte == 8'd0 ||
              {1'b0, bus.in_byte} > 9'(Instruction_Memory_Size)) begin
            state_d = ERROR;
          end else begin
            n_d     = bus.in_byte;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          shift_d = shift_ext[Instruction_WIDTH-1:0];
          csum_d  = csum_q ^ bus.in_byte;
          if (byte_cnt_q == 3'(BYTES_PER_INST - 1)) begin
            byte_cnt_d = '0;
            state_d    = WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 8'd1;
        state_d = (words_q + 8'd1 == n_q) ? CHECK : PAYLOAD;
      end
      CHECK: begin
        if (accept) begin
          state_d = (bus.in_byte == csum_q) ? DONE : ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == HEADER) || (state_q == PAYLOAD) || (state_q == CHECK);
    bus.wr_en    = (state_q == WRITE);
    bus.wr_addr  = addr_q;
    bus.wr_data  = shift_q;
    cu_enable    = (state_q == DONE);
    load_done    = (state_q == DONE);
    load_err     = (state_q == ERROR);
    words_loaded = words_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal, bad checksum, header bounds,
// full image, gapped stream, reload and mid-load reset.
module tb_program_loader;
  logic       clock = 1'b0;
  logic       reset_bt = 1'b0;
  logic       load_start = 1'b0;
  logic       cu_enable, load_done, load_err;
  logic [7:0] words_loaded;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [3:0]  wa[$];
  logic [15:0] wd[$];
  logic [7:0]  stim[$];
  int          waits[$];

  program_loader_if #(.DATA_W(16), .ADDR_W(4)) ifc ();

  program_loader #(
    .Instruction_WIDTH(16),
    .Instruction_Memory_Size(16)
  ) dut (
    .clock(clock),
    .reset_bt(reset_bt),
    .load_start(load_start),
    .bus(ifc.master),
    .cu_enable(cu_enable),
    .load_done(load_done),
    .load_err(load_err),
    .words_loaded(words_loaded),
    .state(state)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ifc.wr_en) begin
      wa.push_back(ifc.wr_addr);
      wd.push_back(ifc.wr_data);
      if (ifc.in_ready || state != 3'd3) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int w);
    ifc.in_byte  = b;
    ifc.in_valid = 1'b1;
    w = 0;
    while (!ifc.in_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    if (!ifc.in_ready) check("send_timeout", 32'd1, 32'd0);
    else @(negedge clock);
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_stream(input int gap);
    int w;
    waits.delete();
    foreach (stim[i]) begin
      send_byte(stim[i], w);
      waits.push_back(w);
      repeat (gap) @(negedge clock);
    end
  endtask

  task automatic normal_stim();
    stim = '{8'h02, 8'h14, 8'h05, 8'h24, 8'h06, 8'h33};
  endtask

  task automatic check_normal(input string tag);
    check({tag, "_nwr"}, wa.size(), 2);
    if (wa.size() == 2) begin
      check({tag, "_a0"}, wa[0], 0);
      check({tag, "_d0"}, wd[0], 16'h1405);
      check({tag, "_a1"}, wa[1], 1);
      check({tag, "_d1"}, wd[1], 16'h2406);
    end
    check({tag, "_words"}, words_loaded, 2);
    check({tag, "_done"}, load_done, 1);
    check({tag, "_cuen"}, cu_enable, 1);
    check({tag, "_err"}, load_err, 0);
    check({tag, "_state"}, state, 5);
  endtask

  initial begin
    logic [7:0] cs;
    int w;
    ifc.in_byte  = 8'h00;
    ifc.in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_state", state, 0);
    check("rst_ready", ifc.in_ready, 0);
    check("rst_wr_en", ifc.wr_en, 0);
    reset_bt = 1'b1;
    @(negedge clock);

    // Normal load, no gaps; bytes after a word wait one cycle for WRITE
    wa.delete(); wd.delete();
    pulse_start();
    check("norm_hdr_state", state, 1);
    normal_stim();
    run_stream(0);
    check("norm_wait_b3", waits[3], 1);
    check("norm_wait_cs", waits[5], 1);
    check_normal("norm");

    // Bad checksum
    wa.delete(); wd.delete();
    pulse_start();
    normal_stim();
    stim[5] = 8'h34;
    run_stream(0);
    check("badcs_nwr", wa.size(), 2);
    check("badcs_err", load_err, 1);
    check("badcs_cuen", cu_enable, 0);
    check("badcs_done", load_done, 0);

    // Header bounds
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00, w);
    check("hdr0_state", state, 6);
    check("hdr0_err", load_err, 1);
    pulse_start();
    send_byte(8'h11, w);
    check("hdr17_state", state, 6);
    repeat (3) @(negedge clock);
    check("hdr_nwr", wa.size(), 0);

    // Full 16-word image
    wa.delete(); wd.delete();
    pulse_start();
    stim.delete();
    stim.push_back(8'h10);
    cs = 8'h00;
    for (int i = 0; i < 16; i++) begin
      stim.push_back(8'(i * 3));
      stim.push_back(8'h5A ^ 8'(i));
      cs = cs ^ 8'(i * 3) ^ 8'h5A ^ 8'(i);
    end
    stim.push_back(cs);
    run_stream(0);
    check("full_nwr", wa.size(), 16);
    if (wa.size() == 16) begin
      check("full_a15", wa[15], 15);
      check("full_d15", wd[15], 16'h2D55);
      check("full_d7", wd[7], 16'h155D);
    end
    check("full_state", state, 5);
    check("full_words", words_loaded, 16);

    // Gapped stream
    wa.delete(); wd.delete();
    pulse_start();
    normal_stim();
    run_stream(3);
    check("gap_wait_b3", waits[3], 0);
    check_normal("gap");

    // Reload from DONE; cu_enable must drop at the load_start edge
    wa.delete(); wd.delete();
    @(negedge clock);
    load_start = 1'b1;
    @(posedge clock);
    #1;
    check("rel_cuen_edge", cu_enable, 0);
    check("rel_state_edge", state, 1);
    @(negedge clock);
    load_start = 1'b0;
    stim = '{8'h01, 8'h80, 8'h00, 8'h80};
    run_stream(0);
    check("rel_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      check("rel_a0", wa[0], 0);
      check("rel_d0", wd[0], 16'h8000);
    end
    check("rel_state", state, 5);
    check("rel_words", words_loaded, 1);

    // Reset after the third payload byte
    wa.delete(); wd.delete();
    pulse_start();
    stim = '{8'h02, 8'h14, 8'h05, 8'h24};
    run_stream(0);
    #2;
    reset_bt = 1'b0;
    #1;
    check("mrst_state", state, 0);
    check("mrst_ready", ifc.in_ready, 0);
    check("mrst_wr_en", ifc.wr_en, 0);
    check("mrst_addr", ifc.wr_addr, 0);
    check("mrst_data", ifc.wr_data, 0);
    check("mrst_words", words_loaded, 0);
    check("mrst_flags", {cu_enable, load_done, load_err}, 0);
    @(negedge clock);
    reset_bt = 1'b1;
    wa.delete(); wd.delete();
    pulse_start();
    normal_stim();
    run_stream(0);
    check_normal("fresh");

    check("wr_en_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
